// File: rtl/mac_accum_3_stage_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : mac_accum_3_stage_pkg
//  Purpose  : Shared definitions for the MAC accumulator stage.
//             - state encoding of the frame controller
//             - default parameter values and product width helper
//             - saturation constant helpers derived from the accumulator width
//  Revision : 1.0  initial release
// ============================================================================
package mac_accum_3_stage_pkg;

    // Frame controller state encoding
    localparam int                   c_STATE_W  = 2;
    localparam logic [c_STATE_W-1:0] c_ST_IDLE  = 2'd0;
    localparam logic [c_STATE_W-1:0] c_ST_ACCUM = 2'd1;
    localparam logic [c_STATE_W-1:0] c_ST_DONE  = 2'd2;

    // Default parameter values for the top level
    localparam int c_A_WIDTH_DEF   = 8;
    localparam int c_B_WIDTH_DEF   = 8;
    localparam int c_ACC_WIDTH_DEF = 24;
    localparam int c_CNT_WIDTH_DEF = 8;
    localparam int c_MULT_LAT_DEF  = 2;

    // Width of the multiplier result for a given operand pair
    function automatic int prod_width(input int a_w, input int b_w);
        return a_w + b_w;
    endfunction

    // Saturation patterns for an accumulator of width acc_w (acc_w < 64).
    // Returned right-aligned in 64 bits; callers size-cast to their width.
    function automatic logic [63:0] sat_max_signed(input int acc_w);
        return (64'd1 << (acc_w - 1)) - 64'd1;
    endfunction

    function automatic logic [63:0] sat_min_signed(input int acc_w);
        return 64'd1 << (acc_w - 1);
    endfunction

    function automatic logic [63:0] sat_max_unsigned(input int acc_w);
        return (64'd1 << acc_w) - 64'd1;
    endfunction

endpackage : mac_accum_3_stage_pkg
`default_nettype wire

// File: rtl/mac_valid_pipe.sv
`default_nettype none
// ============================================================================
//  Module   : mac_valid_pipe
//  Purpose  : DEPTH-deep shift register carrying an issue token alongside the
//             multiplier pipeline, so the token emerges in the same cycle as
//             the matching PRODUCT.
//  Ports    : CLK      rising-edge clock
//             RST      asynchronous active-high reset (clears all tokens)
//             i_valid  token entering this cycle
//             o_valid  token leaving after DEPTH clock edges
//  Revision : 1.0  initial release
// ============================================================================
module mac_valid_pipe #(
    parameter int DEPTH = 2
) (
    input  logic CLK,
    input  logic RST,
    input  logic i_valid,
    output logic o_valid
);

    logic [DEPTH-1:0] r_shift;

    generate
        if (DEPTH == 1) begin : g_single
            always_ff @(posedge CLK or posedge RST) begin
                if (RST) begin
                    r_shift <= '0;
                end else begin
                    r_shift <= i_valid;
                end
            end
        end else begin : g_multi
            always_ff @(posedge CLK or posedge RST) begin
                if (RST) begin
                    r_shift <= '0;
                end else begin
                    r_shift <= {r_shift[DEPTH-2:0], i_valid};
                end
            end
        end
    endgenerate

    assign o_valid = r_shift[DEPTH-1];

endmodule : mac_valid_pipe
`default_nettype wire

// File: rtl/mac_accum_3_stage.sv
`default_nettype none
// ============================================================================
//  Module   : mac_accum_3_stage
//  Purpose  : Accumulator / frame controller sitting behind a pipelined
//             multiplier. Counts operand issues, delays a valid token by the
//             multiplier latency, sums LEN products (signed or unsigned, with
//             saturation) and presents the frame sum on a valid/ready port.
//  Ports    : CLK        rising-edge clock (shared with the multiplier)
//             RST        asynchronous active-high reset
//             START      frame start (honoured in IDLE, or in DONE with
//                        OUT_READY)
//             LEN        products per frame, latched on START
//             TC         1 = signed frame, latched on START
//             IN_VALID   upstream presents an operand pair
//             IN_READY   operand pair accepted when IN_VALID & IN_READY
//             PRODUCT    multiplier result
//             SUM        frame sum, stable while OUT_VALID
//             OUT_VALID  SUM valid
//             OUT_READY  consumer accepts SUM
//             OVF        sticky saturation flag of the frame
//             BUSY       frame in progress or result pending
//  Revision : 1.0  initial release
// ============================================================================
module mac_accum_3_stage
    import mac_accum_3_stage_pkg::*;
#(
    parameter int A_WIDTH   = c_A_WIDTH_DEF,
    parameter int B_WIDTH   = c_B_WIDTH_DEF,
    parameter int ACC_WIDTH = c_ACC_WIDTH_DEF,   // must be >= A_WIDTH+B_WIDTH
    parameter int CNT_WIDTH = c_CNT_WIDTH_DEF,
    parameter int MULT_LAT  = c_MULT_LAT_DEF
) (
    input  logic                       CLK,
    input  logic                       RST,
    input  logic                       START,
    input  logic [CNT_WIDTH-1:0]       LEN,
    input  logic                       TC,
    input  logic                       IN_VALID,
    output logic                       IN_READY,
    input  logic [A_WIDTH+B_WIDTH-1:0] PRODUCT,
    output logic [ACC_WIDTH-1:0]       SUM,
    output logic                       OUT_VALID,
    input  logic                       OUT_READY,
    output logic                       OVF,
    output logic                       BUSY
);

    localparam int c_PROD_W = prod_width(A_WIDTH, B_WIDTH);

    localparam logic [ACC_WIDTH-1:0] c_SAT_POS  = ACC_WIDTH'(sat_max_signed(ACC_WIDTH));
    localparam logic [ACC_WIDTH-1:0] c_SAT_NEG  = ACC_WIDTH'(sat_min_signed(ACC_WIDTH));
    localparam logic [ACC_WIDTH-1:0] c_SAT_UMAX = ACC_WIDTH'(sat_max_unsigned(ACC_WIDTH));

    // ------------------------------------------------------------------
    // State and datapath registers
    // ------------------------------------------------------------------
    logic [c_STATE_W-1:0] r_state;
    logic [c_STATE_W-1:0] w_state_nxt;

    logic [CNT_WIDTH-1:0] r_len;
    logic                 r_tc;
    logic [CNT_WIDTH-1:0] r_issue_cnt;
    logic [CNT_WIDTH-1:0] r_acc_cnt;
    logic [ACC_WIDTH-1:0] r_sum;
    logic                 r_ovf;

    logic w_start_frame;
    logic w_issue;
    logic w_prod_valid;
    logic w_acc_en;
    logic w_last_acc;

    // START is honoured from IDLE, or from DONE only when the pending sum is
    // taken in the same cycle (back-to-back frames).
    assign w_start_frame = START &&
                           ((r_state == c_ST_IDLE) ||
                            ((r_state == c_ST_DONE) && OUT_READY));

    assign w_issue    = IN_VALID && IN_READY;
    assign w_acc_en   = (r_state == c_ST_ACCUM) && w_prod_valid;
    assign w_last_acc = w_acc_en && ((r_acc_cnt + CNT_WIDTH'(1)) == r_len);

    // ------------------------------------------------------------------
    // Issue token delay matching the multiplier depth
    // ------------------------------------------------------------------
    mac_valid_pipe #(
        .DEPTH (MULT_LAT)
    ) u_valid_pipe (
        .CLK     (CLK),
        .RST     (RST),
        .i_valid (w_issue),
        .o_valid (w_prod_valid)
    );

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next state and state-decoded outputs
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        IN_READY    = 1'b0;
        OUT_VALID   = 1'b0;
        BUSY        = 1'b0;

        case (r_state)
            c_ST_IDLE: begin
                if (START) begin
                    w_state_nxt = (LEN == '0) ? c_ST_DONE : c_ST_ACCUM;
                end
            end

            c_ST_ACCUM: begin
                BUSY     = 1'b1;
                IN_READY = (r_issue_cnt < r_len);
                if (w_last_acc) begin
                    w_state_nxt = c_ST_DONE;
                end
            end

            c_ST_DONE: begin
                BUSY      = 1'b1;
                OUT_VALID = 1'b1;
                if (OUT_READY) begin
                    if (START) begin
                        w_state_nxt = (LEN == '0) ? c_ST_DONE : c_ST_ACCUM;
                    end else begin
                        w_state_nxt = c_ST_IDLE;
                    end
                end
            end

            default: begin
                w_state_nxt = c_ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Product extension and saturating add
    // ------------------------------------------------------------------
    logic signed [c_PROD_W-1:0]  w_prod_s;
    logic        [ACC_WIDTH-1:0] w_prod_ext;
    logic        [ACC_WIDTH:0]   w_add;
    logic        [ACC_WIDTH-1:0] w_raw;
    logic                        w_carry;
    logic                        w_ovf_signed;
    logic        [ACC_WIDTH-1:0] w_sum_nxt;
    logic                        w_sat;

    assign w_prod_s   = $signed(PRODUCT);
    assign w_prod_ext = r_tc ? ACC_WIDTH'(w_prod_s) : ACC_WIDTH'(PRODUCT);

    // One extra bit captures the unsigned carry-out.
    assign w_add   = {1'b0, r_sum} + {1'b0, w_prod_ext};
    assign w_raw   = w_add[ACC_WIDTH-1:0];
    assign w_carry = w_add[ACC_WIDTH];

    // Two's-complement overflow: like-signed addends, result sign flipped.
    assign w_ovf_signed = (r_sum[ACC_WIDTH-1] == w_prod_ext[ACC_WIDTH-1]) &&
                          (w_raw[ACC_WIDTH-1] != r_sum[ACC_WIDTH-1]);

    always_comb begin
        w_sum_nxt = w_raw;
        w_sat     = 1'b0;
        if (r_tc) begin
            if (w_ovf_signed) begin
                w_sat     = 1'b1;
                w_sum_nxt = r_sum[ACC_WIDTH-1] ? c_SAT_NEG : c_SAT_POS;
            end
        end else begin
            if (w_carry) begin
                w_sat     = 1'b1;
                w_sum_nxt = c_SAT_UMAX;
            end
        end
    end

    // ------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_len       <= '0;
            r_tc        <= 1'b0;
            r_issue_cnt <= '0;
            r_acc_cnt   <= '0;
            r_sum       <= '0;
            r_ovf       <= 1'b0;
        end else if (w_start_frame) begin
            r_len       <= LEN;
            r_tc        <= TC;
            r_issue_cnt <= '0;
            r_acc_cnt   <= '0;
            r_sum       <= '0;
            r_ovf       <= 1'b0;
        end else begin
            if (w_issue) begin
                r_issue_cnt <= r_issue_cnt + CNT_WIDTH'(1);
            end
            if (w_acc_en) begin
                r_acc_cnt <= r_acc_cnt + CNT_WIDTH'(1);
                r_sum     <= w_sum_nxt;
                if (w_sat) begin
                    r_ovf <= 1'b1;
                end
            end
        end
    end

    assign SUM = r_sum;
    assign OVF = r_ovf;

endmodule : mac_accum_3_stage
`default_nettype wire

// File: tb/tb_mac_accum_3_stage.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mac_accum_3_stage
//  Purpose  : Self-checking bench for mac_accum_3_stage. Two instances (24-bit
//             and 18-bit accumulators) share one stimulus stream; expected
//             sums come from an arithmetic model of the frame rules.
//  Revision : 1.0  initial release
// ============================================================================
module tb_mac_accum_3_stage;

    logic        CLK = 1'b0;
    logic        RST = 1'b0;
    logic        START = 1'b0;
    logic [7:0]  LEN = 8'd0;
    logic        TC = 1'b0;
    logic        IN_VALID = 1'b0;
    logic        OUT_READY = 1'b0;
    logic [15:0] PRODUCT;
    logic [15:0] mult_in = 16'd0;
    logic [15:0] mult_p1;

    logic        in_ready_a, out_valid_a, ovf_a, busy_a;
    logic [23:0] sum_a;
    logic        in_ready_b, out_valid_b, ovf_b, busy_b;
    logic [17:0] sum_b;

    int n_total = 0;
    int n_bad   = 0;

    int          cur_len;
    bit          cur_tc;
    logic [31:0] exp_a, exp_b;
    bit          eovf_a, eovf_b;

    mac_accum_3_stage #(
        .A_WIDTH(8), .B_WIDTH(8), .ACC_WIDTH(24), .CNT_WIDTH(8), .MULT_LAT(2)
    ) dut_a (
        .CLK(CLK), .RST(RST), .START(START), .LEN(LEN), .TC(TC),
        .IN_VALID(IN_VALID), .IN_READY(in_ready_a), .PRODUCT(PRODUCT),
        .SUM(sum_a), .OUT_VALID(out_valid_a), .OUT_READY(OUT_READY),
        .OVF(ovf_a), .BUSY(busy_a)
    );

    mac_accum_3_stage #(
        .A_WIDTH(8), .B_WIDTH(8), .ACC_WIDTH(18), .CNT_WIDTH(8), .MULT_LAT(2)
    ) dut_b (
        .CLK(CLK), .RST(RST), .START(START), .LEN(LEN), .TC(TC),
        .IN_VALID(IN_VALID), .IN_READY(in_ready_b), .PRODUCT(PRODUCT),
        .SUM(sum_b), .OUT_VALID(out_valid_b), .OUT_READY(OUT_READY),
        .OVF(ovf_b), .BUSY(busy_b)
    );

    always #5 CLK = ~CLK;

    // Two-register multiplier stand-in: the value presented with an issue
    // appears on PRODUCT two edges later.
    always @(posedge CLK) begin
        mult_p1 <= mult_in;
        PRODUCT <= mult_p1;
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    // Frame sum with clamping to the representable range of a w-bit
    // accumulator, evaluated on exact integers.
    function automatic logic [31:0] model_sum(input int w, input bit tc,
                                              input logic [15:0] prods[$],
                                              input int n, output bit ovf);
        longint one = 1;
        longint acc = 0;
        longint mx, mn, p;
        ovf = 1'b0;
        mx  = tc ? (one << (w - 1)) - 1 : (one << w) - 1;
        mn  = tc ? -(one << (w - 1)) : 0;
        for (int i = 0; i < n; i++) begin
            p   = tc ? longint'($signed(prods[i])) : longint'(prods[i]);
            acc = acc + p;
            if (acc > mx) begin acc = mx; ovf = 1'b1; end
            if (acc < mn) begin acc = mn; ovf = 1'b1; end
        end
        return 32'(acc & ((one << w) - 1));
    endfunction

    task automatic check_ctl(input string tag, input bit busy, input bit ov, input bit ir);
        check_eq({tag, "_busy_a"}, 32'(busy_a), 32'(busy));
        check_eq({tag, "_ovalid_a"}, 32'(out_valid_a), 32'(ov));
        check_eq({tag, "_iready_a"}, 32'(in_ready_a), 32'(ir));
        check_eq({tag, "_busy_b"}, 32'(busy_b), 32'(busy));
        check_eq({tag, "_ovalid_b"}, 32'(out_valid_b), 32'(ov));
        check_eq({tag, "_iready_b"}, 32'(in_ready_b), 32'(ir));
    endtask

    task automatic check_res(input string tag);
        check_eq({tag, "_sum_a"}, 32'(sum_a), exp_a);
        check_eq({tag, "_ovf_a"}, 32'(ovf_a), 32'(eovf_a));
        check_eq({tag, "_sum_b"}, 32'(sum_b), exp_b);
        check_eq({tag, "_ovf_b"}, 32'(ovf_b), 32'(eovf_b));
    endtask

    // Called at posedge+1. With b2b set the current result is taken in the
    // same cycle as the new START.
    task automatic begin_frame(input int len, input bit tc, input bit b2b);
        START     = 1'b1;
        LEN       = 8'(len);
        TC        = tc;
        OUT_READY = b2b;
        @(posedge CLK); #1;
        START     = 1'b0;
        OUT_READY = 1'b0;
        LEN       = 8'($urandom);       // latched copy must be used
        TC        = 1'($urandom);
        cur_len   = len;
        cur_tc    = tc;
        exp_a = 32'd0; exp_b = 32'd0; eovf_a = 1'b0; eovf_b = 1'b0;
        if (len == 0) begin
            check_ctl("start_len0", 1'b1, 1'b1, 1'b0);
            check_res("len0");
        end else begin
            check_ctl("start", 1'b1, 1'b0, 1'b1);
            check_res("cleared");
        end
    endtask

    // Issue cur_len products; pat overrides the random gap choice for the
    // first pat.size() cycles.
    task automatic issue_phase(input logic [15:0] prods[$], input bit pat[$], input int gap_pct);
        int idx = 0;
        int cyc = 0;
        bit iv;
        while (idx < cur_len && cyc < 2000) begin
            iv       = (cyc < pat.size()) ? pat[cyc] : ($urandom_range(99) >= gap_pct);
            IN_VALID = iv;
            mult_in  = prods[idx];
            START    = 1'($urandom);    // ignored while accumulating
            check_eq("issue_ready_a", 32'(in_ready_a), 32'd1);
            check_eq("issue_ready_b", 32'(in_ready_b), 32'd1);
            @(posedge CLK); #1;
            if (iv) idx++;
            cyc++;
        end
        START    = 1'b0;
        IN_VALID = 1'b1;                // no ready: must be ignored
        mult_in  = 16'($urandom);
        if (idx < cur_len) check_eq("issue_timeout", 32'(idx), 32'(cur_len));
        exp_a = model_sum(24, cur_tc, prods, cur_len, eovf_a);
        exp_b = model_sum(18, cur_tc, prods, cur_len, eovf_b);
        check_ctl("issued", 1'b1, 1'b0, 1'b0);
        @(posedge CLK); #1;
        check_ctl("lat1", 1'b1, 1'b0, 1'b0);
        @(posedge CLK); #1;
        IN_VALID = 1'b0;
        check_ctl("done", 1'b1, 1'b1, 1'b0);
        check_res("sum");
    endtask

    task automatic hold_done(input int hold);
        for (int i = 0; i < hold; i++) begin
            START    = 1'($urandom);
            IN_VALID = 1'b1;
            LEN      = 8'($urandom);
            @(posedge CLK); #1;
            check_ctl("hold", 1'b1, 1'b1, 1'b0);
            check_res("hold");
        end
        START    = 1'b0;
        IN_VALID = 1'b0;
    endtask

    task automatic release_done();
        OUT_READY = 1'b1;
        @(posedge CLK); #1;
        OUT_READY = 1'b0;
        check_ctl("idle", 1'b0, 1'b0, 1'b0);
    endtask

    initial begin : main
        logic [15:0] q[$];
        bit          pat[$];
        bit          nopat[$];
        int          len;
        nopat = {};

        // Reset state
        #2 RST = 1'b1;
        repeat (2) @(posedge CLK);
        #1;
        check_ctl("reset", 1'b0, 1'b0, 1'b0);
        check_eq("reset_sum_a", 32'(sum_a), 32'd0);
        check_eq("reset_ovf_a", 32'(ovf_a), 32'd0);
        @(negedge CLK) RST = 1'b0;
        @(posedge CLK); #1;

        // Unsigned LEN=4: 10+20+30+40
        begin_frame(4, 1'b0, 1'b0);
        q = {16'd10, 16'd20, 16'd30, 16'd40};
        issue_phase(q, nopat, 0);
        check_eq("u4_const", 32'(sum_a), 32'h64);
        release_done();

        // Signed and unsigned interpretation of the same products
        begin_frame(2, 1'b1, 1'b0);
        q = {16'hFFF1, 16'h0007};
        issue_phase(q, nopat, 0);
        check_eq("s2_const", 32'(sum_a), 32'hFFFFF8);
        release_done();
        begin_frame(2, 1'b0, 1'b0);
        issue_phase(q, nopat, 0);
        check_eq("u2_const", 32'(sum_a), 32'h00FFF8);
        release_done();

        // Saturation: positive signed, unsigned carry, negative signed
        begin_frame(8, 1'b1, 1'b0);
        q = {};
        for (int i = 0; i < 8; i++) q.push_back(16'h4000);
        issue_phase(q, nopat, 0);
        check_eq("sat_s_const", 32'(sum_b), 32'h1FFFF);
        release_done();
        begin_frame(5, 1'b0, 1'b0);
        q = {};
        for (int i = 0; i < 5; i++) q.push_back(16'hFE01);
        issue_phase(q, nopat, 0);
        check_eq("sat_u_const", 32'(sum_b), 32'h3FFFF);
        release_done();
        begin_frame(6, 1'b1, 1'b0);
        q = {};
        for (int i = 0; i < 6; i++) q.push_back(16'h8000);
        issue_phase(q, nopat, 0);
        release_done();

        // Backpressure then back-to-back frame
        begin_frame(3, 1'b0, 1'b0);
        q = {16'd1000, 16'd2000, 16'd3000};
        issue_phase(q, nopat, 0);
        hold_done(5);
        begin_frame(2, 1'b1, 1'b1);
        q = {16'hFF00, 16'h0123};
        issue_phase(q, nopat, 0);
        release_done();

        // LEN=0 frame
        begin_frame(0, 1'b0, 1'b0);
        hold_done(1);
        release_done();

        // Gapped issues 1,0,0,1,1
        begin_frame(3, 1'b0, 1'b0);
        q   = {16'd5, 16'd6, 16'd7};
        pat = {1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
        issue_phase(q, pat, 0);
        release_done();

        // Asynchronous reset with two products in flight
        begin_frame(5, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            IN_VALID = 1'b1;
            mult_in  = 16'(100 + i);
            @(posedge CLK); #1;
        end
        IN_VALID = 1'b0;
        #2 RST = 1'b1;
        #1;
        check_ctl("async_rst", 1'b0, 1'b0, 1'b0);
        check_eq("async_rst_sum", 32'(sum_a), 32'd0);
        check_eq("async_rst_ovf", 32'(ovf_a), 32'd0);
        @(negedge CLK) RST = 1'b0;
        repeat (3) @(posedge CLK);
        #1;
        check_ctl("post_rst", 1'b0, 1'b0, 1'b0);
        begin_frame(1, 1'b0, 1'b0);
        q = {16'd9};
        issue_phase(q, nopat, 0);
        check_eq("post_rst_const", 32'(sum_a), 32'd9);
        release_done();

        // Randomized frames, optionally back-to-back
        for (int f = 0; f < 24; f++) begin
            bit b2b;
            b2b = (f > 0) && ($urandom_range(1) == 1);
            if (f > 0 && !b2b) release_done();
            len = $urandom_range(10);
            begin_frame(len, 1'($urandom), b2b);
            if (len > 0) begin
                q = {};
                for (int i = 0; i < len; i++) begin
                    case ($urandom_range(3))
                        0:       q.push_back(16'h8000);
                        1:       q.push_back(16'h7FFF);
                        default: q.push_back(16'($urandom));
                    endcase
                end
                issue_phase(q, nopat, $urandom_range(60));
            end
            hold_done($urandom_range(3));
        end
        release_done();

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule : tb_mac_accum_3_stage
`default_nettype wire
